systolic_os_stream: RTL and testbench

//  Output-stationary NxN signed MAC array with built-in input skew, a run-time reduction depth (cfg_k)
//  and valid/ready streaming on both input and output. Computes C[i][j] = sum_t A[i][t]*B[t][j] for
//  t=0..cfg_k-1. Successor to the fixed-cycle systolic block: no external cycle_num/matrix_index

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/systolic_pe.sv | 48 ++++
 rtl/systolic_os_stream.sv | 191 +++++++++++++++++++
 tb/tb_systolic_os_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM encoding and width helpers for the systolic MAC family
//
// Purpose: state encoding for the IDLE/FEED/FLUSH/DRAIN controller plus width-derivation helpers
//          shared by the array, the quantiser and the fetch unit.
// Ports:   none (package).
package systolic_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FEED  = 2'd1;
   localparam state_t ST_FLUSH = 2'd2;
   localparam state_t ST_DRAIN = 2'd3;

   // Full product width plus one bit per doubling of the reduction depth: never overflows.
   function automatic int acc_width(input int dw, input int kb);
      return 2 * dw + kb;
   endfunction

   // Index width that never collapses to zero for a 1-entry range.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - single output-stationary signed MAC cell
//
// Purpose: multiplies the operands arriving from the left (a) and from above (w), accumulates the
//          sign-extended product, and forwards both operands one cell on per enabled step.
// Ports:   clk, srstn      clock, synchronous active-low reset
//          en              array step enable; everything holds when low
//          clr             clears accumulator and pass-through regs (new operation)
//          a_in, w_in      operands entering the cell
//          a_out, w_out    registered operands for the right / lower neighbour
//          acc             registered accumulator
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 25
) (
   input  logic                        clk,
   input  logic                        srstn,
   input  logic                        en,
   input  logic                        clr,
   input  logic signed [DATA_WIDTH-1:0] a_in,
   input  logic signed [DATA_WIDTH-1:0] w_in,
   output logic signed [DATA_WIDTH-1:0] a_out,
   output logic signed [DATA_WIDTH-1:0] w_out,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0]        prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;

   assign prod     = a_in * w_in;
   assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

   always_ff @(posedge clk) begin
      if (!srstn || clr) begin
         a_out <= '0;
         w_out <= '0;
         acc   <= '0;
      end else if (en) begin
         a_out <= a_in;
         w_out <= w_in;
         acc   <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/systolic_os_stream.sv
// rtl/systolic_os_stream.sv - streaming output-stationary NxN signed MAC array with input skew
//
// Purpose: computes C = A*B over a run-time depth cfg_k. Beats (column of A, row of B) stream in
//          over valid/ready, the array is flushed with zeros, then rows of C stream out.
// Ports:   clk, srstn                  clock, synchronous active-low reset
//          start, cfg_k                start request and reduction depth (IDLE only)
//          busy, done                  operation in progress / one-cycle completion pulse
//          in_valid, in_ready          input beat handshake
//          in_d, in_w                  A column lanes / B row lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//          out_valid, out_ready        result row handshake
//          out_row, out_row_idx        row of C (column j at [j*ACC_WIDTH +: ACC_WIDTH]) and its index
module systolic_os_stream
   import systolic_pkg::*;
#(
   parameter int ARRAY_SIZE = 8,
   parameter int DATA_WIDTH = 8,
   parameter int K_BITS     = 9,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K_BITS),
   parameter int IDX_BITS   = idx_width(ARRAY_SIZE)
) (
   input  logic                             clk,
   input  logic                             srstn,
   input  logic                             start,
   input  logic [K_BITS-1:0]                cfg_k,
   output logic                             busy,
   output logic                             done,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_d,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_w,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
   output logic [IDX_BITS-1:0]              out_row_idx
);

   localparam int N       = ARRAY_SIZE;
   localparam int DW      = DATA_WIDTH;
   localparam int AW      = ACC_WIDTH;
   localparam int FL_BITS = idx_width(2 * N);

   state_t               state;
   logic [K_BITS-1:0]    k_lat;
   logic [K_BITS-1:0]    beat_cnt;
   logic [FL_BITS-1:0]   flush_cnt;
   logic [IDX_BITS-1:0]  row_idx;
   logic                 done_r;

   logic                 accept;
   logic                 step;
   logic                 clr;

   assign accept = (state == ST_FEED) && in_valid;
   assign step   = accept || (state == ST_FLUSH);
   assign clr    = (state == ST_IDLE) && start && (cfg_k != '0);

   assign busy        = (state != ST_IDLE);
   assign done        = done_r;
   assign in_ready    = (state == ST_FEED);
   assign out_valid   = (state == ST_DRAIN);
   assign out_row_idx = row_idx;

   // ------------------------------------------------------------------ controller
   always_ff @(posedge clk) begin
      if (!srstn) begin
         state     <= ST_IDLE;
         k_lat     <= '0;
         beat_cnt  <= '0;
         flush_cnt <= '0;
         row_idx   <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clr) begin
                  k_lat     <= cfg_k;
                  beat_cnt  <= '0;
                  flush_cnt <= '0;
                  row_idx   <= '0;
                  state     <= ST_FEED;
               end
            end
            ST_FEED: begin
               if (accept) begin
                  if (beat_cnt == k_lat - K_BITS'(1)) state <= ST_FLUSH;
                  else                                beat_cnt <= beat_cnt + K_BITS'(1);
               end
            end
            ST_FLUSH: begin
               // 2N-1 zero steps push the last beat through the skew and the full array diagonal.
               if (flush_cnt == FL_BITS'(2 * N - 2)) state <= ST_DRAIN;
               else                                  flush_cnt <= flush_cnt + FL_BITS'(1);
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (row_idx == IDX_BITS'(N - 1)) begin
                     row_idx <= '0;
                     done_r  <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     row_idx <= row_idx + IDX_BITS'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ input skew
   // Lane k is delayed by k steps so that beat t reaches PE(i,j) on step t+i+j.
   // Outside FEED the lanes see zeros, which is what the flush injects.
   logic signed [DW-1:0] a_edge [N];
   logic signed [DW-1:0] w_edge [N];

   for (genvar k = 0; k < N; k++) begin : g_skew
      logic signed [DW-1:0] a_src;
      logic signed [DW-1:0] w_src;

      assign a_src = (state == ST_FEED) ? $signed(in_d[k*DW +: DW]) : '0;
      assign w_src = (state == ST_FEED) ? $signed(in_w[k*DW +: DW]) : '0;

      if (k == 0) begin : g_direct
         assign a_edge[k] = a_src;
         assign w_edge[k] = w_src;
      end else begin : g_delay
         logic signed [DW-1:0] a_sr [k];
         logic signed [DW-1:0] w_sr [k];

         always_ff @(posedge clk) begin
            if (!srstn || clr) begin
               for (int m = 0; m < k; m++) begin
                  a_sr[m] <= '0;
                  w_sr[m] <= '0;
               end
            end else if (step) begin
               a_sr[0] <= a_src;
               w_sr[0] <= w_src;
               for (int m = 1; m < k; m++) begin
                  a_sr[m] <= a_sr[m-1];
                  w_sr[m] <= w_sr[m-1];
               end
            end
         end

         assign a_edge[k] = a_sr[k-1];
         assign w_edge[k] = w_sr[k-1];
      end
   end

   // ------------------------------------------------------------------ PE array
   logic signed [DW-1:0] a_pass [N][N];
   logic signed [DW-1:0] w_pass [N][N];
   logic signed [AW-1:0] acc_q  [N][N];

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [DW-1:0] a_in;
         logic signed [DW-1:0] w_in;

         assign a_in = (j == 0) ? a_edge[i] : a_pass[i][(j > 0) ? j - 1 : 0];
         assign w_in = (i == 0) ? w_edge[j] : w_pass[(i > 0) ? i - 1 : 0][j];

         systolic_pe #(
            .DATA_WIDTH (DW),
            .ACC_WIDTH  (AW)
         ) u_pe (
            .clk   (clk),
            .srstn (srstn),
            .en    (step),
            .clr   (clr),
            .a_in  (a_in),
            .w_in  (w_in),
            .a_out (a_pass[i][j]),
            .w_out (w_pass[i][j]),
            .acc   (acc_q[i][j])
         );
      end
   end

   // ------------------------------------------------------------------ output mux
   // Accumulators hold during DRAIN, so the row is stable for as long as out_ready stays low.
   always_comb begin
      out_row = '0;
      if (state == ST_DRAIN) begin
         for (int j = 0; j < N; j++) out_row[j*AW +: AW] = acc_q[row_idx][j];
      end
   end

endmodule

// File: tb/tb_systolic_os_stream.sv
// tb/tb_systolic_os_stream.sv - self-checking bench for systolic_os_stream
module tb_systolic_os_stream;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int KB = 9;
   localparam int AW = 2 * DW + KB;
   localparam int IB = 3;

   typedef struct {
      int                  idx;
      logic [N*AW-1:0]     row;
   } exp_t;

   logic              clk = 1'b0;
   logic              srstn = 1'b0;
   logic              start = 1'b0;
   logic [KB-1:0]     cfg_k = '0;
   logic              busy;
   logic              done;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [N*DW-1:0]   in_d = '0;
   logic [N*DW-1:0]   in_w = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [N*AW-1:0]   out_row;
   logic [IB-1:0]     out_row_idx;

   int                vecs = 0;
   int                fails = 0;
   int                cyc = 0;
   int                done_cnt = 0;
   int                a_m [N][512];
   int                b_m [512][N];
   exp_t              sbq [$];
   logic [AW-1:0]     last_row0;

   systolic_os_stream #(
      .ARRAY_SIZE (N),
      .DATA_WIDTH (DW),
      .K_BITS     (KB),
      .ACC_WIDTH  (AW),
      .IDX_BITS   (IB)
   ) dut (
      .clk         (clk),
      .srstn       (srstn),
      .start       (start),
      .cfg_k       (cfg_k),
      .busy        (busy),
      .done        (done),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_d        (in_d),
      .in_w        (in_w),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      vecs++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input int k);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.idx = i;
         e.row = '0;
         for (int j = 0; j < N; j++) begin
            longint s;
            s = 0;
            for (int t = 0; t < k; t++) s += longint'(a_m[i][t]) * longint'(b_m[t][j]);
            e.row[j*AW +: AW] = s[AW-1:0];
         end
         sbq.push_back(e);
      end
   endtask

   task automatic drive_beat(input int t);
      for (int i = 0; i < N; i++) begin
         in_d[i*DW +: DW] = DW'(a_m[i][t]);
         in_w[i*DW +: DW] = DW'(b_m[t][i]);
      end
   endtask

   task automatic run_op(input int k, input bit gaps, input int stall_row, input bit chk_lat, input string nm);
      int   c0;
      int   t;
      int   guard;
      int   d0;
      bit   rdy;
      exp_t e;
      push_expected(k);
      d0    = done_cnt;
      cfg_k = KB'(k);
      start = 1'b1;
      tick();
      c0    = cyc;
      start = 1'b0;
      chk({nm, "_busy"}, 256'(busy), 256'(1));
      t = 0;
      guard = 0;
      while (t < k && guard < 20000) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         drive_beat(t);
         start = (t == 1);
         rdy = in_ready;
         tick();
         start = 1'b0;
         if (in_valid && rdy) t++;
         guard++;
      end
      in_valid = 1'b0;
      chk({nm, "_beats"}, 256'(t), 256'(k));
      guard = 0;
      while (!out_valid && guard < 100) begin
         tick();
         guard++;
      end
      chk({nm, "_out_valid"}, 256'(out_valid), 256'(1));
      if (chk_lat) chk({nm, "_first_valid_cyc"}, 256'(cyc - c0), 256'(k + 2 * N - 1));
      for (int r = 0; r < N; r++) begin
         e = sbq.pop_front();
         if (r == stall_row) begin
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               chk({nm, "_stall_valid"}, 256'(out_valid), 256'(1));
               chk({nm, "_stall_idx"}, 256'(out_row_idx), 256'(e.idx));
               chk({nm, "_stall_row"}, 256'(out_row), 256'(e.row));
               tick();
            end
         end
         out_ready = 1'b1;
         start = (r == 1);
         chk({nm, "_idx"}, 256'(out_row_idx), 256'(e.idx));
         chk({nm, "_row"}, 256'(out_row), 256'(e.row));
         if (r == 0) last_row0 = out_row[AW-1:0];
         tick();
         start = 1'b0;
      end
      out_ready = 1'b0;
      chk({nm, "_done"}, 256'(done), 256'(1));
      chk({nm, "_busy_end"}, 256'(busy), 256'(0));
      if (chk_lat) chk({nm, "_done_cyc"}, 256'(cyc - c0), 256'(k + 3 * N - 1));
      tick();
      chk({nm, "_done_pulse"}, 256'(done), 256'(0));
      chk({nm, "_done_count"}, 256'(done_cnt), 256'(d0 + 1));
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_row", 256'(out_row), 256'(0));
      chk("rst_out_idx", 256'(out_row_idx), 256'(0));
      srstn = 1'b1;
      tick();

      // start with cfg_k = 0 is ignored
      cfg_k = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("k0_busy", 256'(busy), 256'(0));
      chk("k0_in_ready", 256'(in_ready), 256'(0));
      tick();

      // identity A, B = 1..64 row-major, exact latency
      for (int i = 0; i < N; i++)
         for (int t = 0; t < N; t++) a_m[i][t] = (i == t) ? 1 : 0;
      for (int t = 0; t < N; t++)
         for (int j = 0; j < N; j++) b_m[t][j] = t * N + j + 1;
      run_op(N, 1'b0, -1, 1'b1, "t1_ident");

      // deepest reduction with the most negative operands
      for (int t = 0; t < 511; t++)
         for (int i = 0; i < N; i++) begin
            a_m[i][t] = -128;
            b_m[t][i] = -128;
         end
      run_op(511, 1'b0, -1, 1'b1, "t2_kmax");
      chk("t2_const", 256'(last_row0), 256'(25'd8372224));

      // random data, gap-free then with random input gaps and an output stall at row 2
      for (int t = 0; t < 37; t++)
         for (int i = 0; i < N; i++) begin
            a_m[i][t] = int'($urandom_range(0, 255)) - 128;
            b_m[t][i] = int'($urandom_range(0, 255)) - 128;
         end
      run_op(37, 1'b0, -1, 1'b0, "t3_nogap");
      run_op(37, 1'b1, 2, 1'b0, "t3_gaps");

      // reset in the middle of FEED, then a short clean operation
      for (int t = 0; t < 10; t++)
         for (int i = 0; i < N; i++) begin
            a_m[i][t] = 100 - i;
            b_m[t][i] = 50 + t;
         end
      cfg_k = KB'(10);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         in_valid = 1'b1;
         drive_beat(t);
         tick();
      end
      in_valid = 1'b0;
      srstn = 1'b0;
      tick();
      chk("t5_rst_busy", 256'(busy), 256'(0));
      chk("t5_rst_in_ready", 256'(in_ready), 256'(0));
      chk("t5_rst_out_valid", 256'(out_valid), 256'(0));
      chk("t5_rst_out_row", 256'(out_row), 256'(0));
      srstn = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
         a_m[i][0] = 2;
         b_m[0][i] = 3;
      end
      run_op(1, 1'b0, -1, 1'b1, "t5_after_rst");
      chk("t5_const", 256'(last_row0), 256'(6));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
